// File: rtl/csa_cpa_pipe.sv
// csa_cpa_pipe: two-stage carry-propagate adder for the CSA sum/carry pair.
// Ports: clk_i, rst_ni, in_valid_i/in_ready_o, sum_i, carry_i,
//        out_valid_o/out_ready_i, result_o, cout_o.
module csa_cpa_pipe #(
  parameter int WIDTH    = 10,
  parameter int LO_WIDTH = WIDTH / 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o
);

  localparam int HI_WIDTH = WIDTH - LO_WIDTH;

  if (LO_WIDTH < 1 || LO_WIDTH > WIDTH - 1) begin : g_bad_lo
    $error("csa_cpa_pipe: LO_WIDTH must be in 1..WIDTH-1");
  end

  // Stage 1: low half sum plus raw high slices.
  logic                s1_valid_q;
  logic                s1_valid_d;
  logic [LO_WIDTH-1:0] s1_lo_q;
  logic [LO_WIDTH-1:0] s1_lo_d;
  logic                s1_clo_q;
  logic                s1_clo_d;
  logic [HI_WIDTH-1:0] s1_sum_hi_q;
  logic [HI_WIDTH-1:0] s1_sum_hi_d;
  logic [HI_WIDTH-1:0] s1_car_hi_q;
  logic [HI_WIDTH-1:0] s1_car_hi_d;

  // Stage 2: full result.
  logic                s2_valid_q;
  logic                s2_valid_d;
  logic [WIDTH-1:0]    s2_res_q;
  logic [WIDTH-1:0]    s2_res_d;
  logic                s2_cout_q;
  logic                s2_cout_d;

  logic                s1_en;
  logic                s2_en;
  logic [LO_WIDTH:0]   lo_add;
  logic [HI_WIDTH:0]   hi_add;

  // A stage may load when empty or when the stage after it moves.
  always_comb begin
    s2_en = !s2_valid_q || out_ready_i;
    s1_en = !s1_valid_q || s2_en;
  end

  assign in_ready_o = s1_en;

  always_comb begin
    lo_add = {1'b0, sum_i[LO_WIDTH-1:0]}
           + {1'b0, carry_i[LO_WIDTH-1:0]};
  end

  // High half absorbs the low-half carry one cycle later.
  always_comb begin
    hi_add = {1'b0, s1_sum_hi_q}
           + {1'b0, s1_car_hi_q}
           + {{HI_WIDTH{1'b0}}, s1_clo_q};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_clo_d    = s1_clo_q;
    s1_sum_hi_d = s1_sum_hi_q;
    s1_car_hi_d = s1_car_hi_q;
    if (s1_en) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_lo_d     = lo_add[LO_WIDTH-1:0];
        s1_clo_d    = lo_add[LO_WIDTH];
        s1_sum_hi_d = sum_i[WIDTH-1:LO_WIDTH];
        s1_car_hi_d = carry_i[WIDTH-1:LO_WIDTH];
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_cout_d  = s2_cout_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d  = {hi_add[HI_WIDTH-1:0], s1_lo_q};
        s2_cout_d = hi_add[HI_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_clo_q    <= 1'b0;
      s1_sum_hi_q <= '0;
      s1_car_hi_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_clo_q    <= s1_clo_d;
      s1_sum_hi_q <= s1_sum_hi_d;
      s1_car_hi_q <= s1_car_hi_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_cout_q  <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_cout_q  <= s2_cout_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign result_o    = s2_res_q;
  assign cout_o      = s2_cout_q;

endmodule

// File: tb/tb_csa_cpa_pipe.sv
// tb_csa_cpa_pipe: directed checks of csa_cpa_pipe at LO_WIDTH 5, 1 and 9.
// All three instances share stimulus and must agree with the expected values.
module tb_csa_cpa_pipe;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [9:0] sum_in = '0;
  logic [9:0] carry_in = '0;
  logic [2:0] ov;
  logic [2:0] ir;
  logic [2:0] co;
  logic [9:0] res0;
  logic [9:0] res1;
  logic [9:0] res2;
  int         total = 0;
  int         bad = 0;
  logic [10:0] q[$];

  always #5 clk = ~clk;

  csa_cpa_pipe #(.WIDTH(10)) u_lo5 (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .sum_i(sum_in), .carry_i(carry_in),
    .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .result_o(res0), .cout_o(co[0])
  );

  csa_cpa_pipe #(.WIDTH(10), .LO_WIDTH(1)) u_lo1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .sum_i(sum_in), .carry_i(carry_in),
    .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .result_o(res1), .cout_o(co[1])
  );

  csa_cpa_pipe #(.WIDTH(10), .LO_WIDTH(9)) u_lo9 (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid), .in_ready_o(ir[2]),
    .sum_i(sum_in), .carry_i(carry_in),
    .out_valid_o(ov[2]), .out_ready_i(out_ready),
    .result_o(res2), .cout_o(co[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(string tag, logic [9:0] r, logic c);
    chk({tag, "_r5"}, {22'd0, res0}, {22'd0, r});
    chk({tag, "_r1"}, {22'd0, res1}, {22'd0, r});
    chk({tag, "_r9"}, {22'd0, res2}, {22'd0, r});
    chk({tag, "_co"}, {29'd0, co}, {29'd0, {3{c}}});
  endtask

  task automatic chk_out(string tag, logic v, logic [9:0] r, logic c);
    chk({tag, "_v"}, {29'd0, ov}, {29'd0, {3{v}}});
    if (v) chk_res(tag, r, c);
  endtask

  task automatic chk_rdy(string tag, logic rdy);
    chk({tag, "_rdy"}, {29'd0, ir}, {29'd0, {3{rdy}}});
  endtask

  task automatic drive(logic [9:0] s, logic [9:0] c);
    in_valid = 1'b1;
    sum_in   = s;
    carry_in = c;
  endtask

  // Single item through an idle pipe: invalid after accept edge, valid next.
  task automatic run_one(string tag, logic [9:0] s, logic [9:0] c,
                         logic [9:0] r, logic co_exp);
    drive(s, c);
    chk_rdy({tag, "_in"}, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out({tag, "_lat1"}, 1'b0, r, co_exp);
    tick();
    chk_out(tag, 1'b1, r, co_exp);
    tick();
    chk_out({tag, "_gone"}, 1'b0, r, co_exp);
  endtask

  task automatic rnd_cycle(string tag);
    logic       acc;
    logic       drn;
    logic [10:0] e;
    #1;
    acc = in_valid && ir[0];
    drn = ov[0] && out_ready;
    if (drn) begin
      if (q.size() == 0) begin
        chk({tag, "_spurious"}, {31'd0, ov[0]}, 32'd0);
      end else begin
        e = q.pop_front();
        chk_out(tag, 1'b1, e[9:0], e[10]);
      end
    end
    if (acc) q.push_back({1'b0, sum_in} + {1'b0, carry_in});
    tick();
  endtask

  initial begin
    // Reset state
    #2 rst_ni = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 10'h000, 1'b0);
    chk_res("rst_async", 10'h000, 1'b0);
    chk_rdy("rst_async", 1'b1);
    tick();
    tick();
    chk_out("rst_hold", 1'b0, 10'h000, 1'b0);
    chk_res("rst_hold", 10'h000, 1'b0);
    chk_rdy("rst_hold", 1'b1);
    #2 rst_ni = 1'b1;
    tick();
    chk_rdy("rst_rel", 1'b1);

    // Basic and boundary adds
    run_one("basic", 10'h155, 10'h0AA, 10'h1FF, 1'b0);
    run_one("split", 10'h01F, 10'h001, 10'h020, 1'b0);
    run_one("wrap", 10'h3FF, 10'h001, 10'h000, 1'b1);
    run_one("maxmax", 10'h3FF, 10'h3FF, 10'h3FE, 1'b1);
    run_one("lo1b", 10'h001, 10'h001, 10'h002, 1'b0);
    run_one("hi9b", 10'h1FF, 10'h001, 10'h200, 1'b0);

    // Streaming (k, 3k) -> 4k, one per cycle
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(10'(i), 10'(3 * i));
      else in_valid = 1'b0;
      chk_rdy("stream", 1'b1);
      tick();
      if (i >= 1) chk_out("stream", 1'b1, 10'(4 * (i - 1)), 1'b0);
    end
    tick();
    chk_out("stream_end", 1'b0, 10'h000, 1'b0);

    // Backpressure
    out_ready = 1'b0;
    drive(10'h010, 10'h005);
    tick();
    chk_rdy("bp_s1", 1'b1);
    drive(10'h020, 10'h007);
    tick();
    chk_out("bp_first", 1'b1, 10'h015, 1'b0);
    chk_rdy("bp_full", 1'b0);
    drive(10'h300, 10'h0FF);
    tick();
    chk_out("bp_hold1", 1'b1, 10'h015, 1'b0);
    chk_rdy("bp_hold1", 1'b0);
    tick();
    chk_out("bp_hold2", 1'b1, 10'h015, 1'b0);
    chk_rdy("bp_hold2", 1'b0);
    out_ready = 1'b1;
    #1;
    chk_rdy("bp_release", 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("bp_second", 1'b1, 10'h027, 1'b0);
    tick();
    chk_out("bp_third", 1'b1, 10'h3FF, 1'b0);
    tick();
    chk_out("bp_empty", 1'b0, 10'h000, 1'b0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(10'h111, 10'h222);
    tick();
    drive(10'h0F0, 10'h00F);
    tick();
    in_valid = 1'b0;
    chk_out("mid_full", 1'b1, 10'h333, 1'b0);
    chk_rdy("mid_full", 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 10'h000, 1'b0);
    chk_res("mid_rst", 10'h000, 1'b0);
    chk_rdy("mid_rst", 1'b1);
    tick();
    #2 rst_ni = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_out("mid_idle", 1'b0, 10'h000, 1'b0);
    run_one("after_rst", 10'h100, 10'h100, 10'h200, 1'b0);

    // Random valid/ready against a scoreboard
    q.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sum_in    = 10'($urandom);
      carry_in  = 10'($urandom);
      rnd_cycle("rnd");
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (q.size() != 0) rnd_cycle("rnd_drain");
    end
    chk("rnd_left", q.size(), 32'd0);
    chk_out("rnd_idle", 1'b0, 10'h000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
